// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-dependency scoreboard and issue controller that
// sits between decode and ID_EX.
//   - One saturating pending-write counter per architectural register
//     (x0 is never tracked).
//   - Decode stalls on a RAW hazard, on counter saturation, or while a drain
//     sequence is active.
//   - The drain sequence blocks issue until every outstanding write retires,
//     then pulses drain_done_o for one cycle.
// Optional build macro: SCB_WB_BYPASS_EN. When it is defined, a source whose
// only pending write retires in the current cycle is not a hazard, because
// the writeback data is forwarded to ID_EX.
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   dec_*_i                    decode instruction: valid, rs1/rs2 reads, rd write
//   issue_ready_o              combinational; issue fires on dec_valid_i & issue_ready_o
//   wb_valid_i, wb_rd_idx_i    one register write retires this cycle
//   flush_i                    clears all pending state and blocks issue
//   drain_req_i                level request to drain outstanding writes
//   drain_done_o               registered one-cycle drain-complete pulse
//   pending_any_o              any counter nonzero (decoded from flops)
//   err_underflow_o            sticky: writeback to a register with no pending write
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dec_valid_i,
  input  logic                        dec_rs1_en_i,
  input  logic [`REG_IDX_WIDTH-1:0]   dec_rs1_idx_i,
  input  logic                        dec_rs2_en_i,
  input  logic [`REG_IDX_WIDTH-1:0]   dec_rs2_idx_i,
  input  logic                        dec_rd_en_i,
  input  logic [`REG_IDX_WIDTH-1:0]   dec_rd_idx_i,
  output logic                        issue_ready_o,
  input  logic                        wb_valid_i,
  input  logic [`REG_IDX_WIDTH-1:0]   wb_rd_idx_i,
  input  logic                        flush_i,
  input  logic                        drain_req_i,
  output logic                        drain_done_o,
  output logic                        pending_any_o,
  output logic                        err_underflow_o
);

  localparam int unsigned      IDX_W   = `REG_IDX_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             drain_done_q, drain_done_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             byp1, byp2;
  logic             hz1, hz2, sat;
  logic             fire, inc_hit, wb_hit, same_reg;
  logic             pending_d;

  // Counter lookups; the loop starts at 1 so index 0 always reads as zero.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    wb_cnt  = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (dec_rs1_idx_i == IDX_W'(r)) rs1_cnt = cnt_q[r];
      if (dec_rs2_idx_i == IDX_W'(r)) rs2_cnt = cnt_q[r];
      if (dec_rd_idx_i  == IDX_W'(r)) rd_cnt  = cnt_q[r];
      if (wb_rd_idx_i   == IDX_W'(r)) wb_cnt  = cnt_q[r];
    end
  end

  // The last pending write to a source retires this cycle and its data is forwarded.
`ifdef SCB_WB_BYPASS_EN
  assign byp1 = wb_valid_i && (wb_rd_idx_i == dec_rs1_idx_i) && (rs1_cnt == CNT_ONE);
  assign byp2 = wb_valid_i && (wb_rd_idx_i == dec_rs2_idx_i) && (rs2_cnt == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Hazard and saturation checks.
  assign hz1 = dec_rs1_en_i && (dec_rs1_idx_i != '0) && (rs1_cnt != '0) && !byp1;
  assign hz2 = dec_rs2_en_i && (dec_rs2_idx_i != '0) && (rs2_cnt != '0) && !byp2;
  assign sat = dec_rd_en_i && (dec_rd_idx_i != '0) && (rd_cnt == CNT_MAX);

  // A drain request blocks issue in the same cycle it arrives.
  assign issue_ready_o = (state_q == ST_RUN) && !drain_req_i && !hz1 && !hz2 && !sat && !flush_i;

  assign fire     = dec_valid_i && issue_ready_o;
  assign inc_hit  = fire && dec_rd_en_i && (dec_rd_idx_i != '0);
  assign wb_hit   = wb_valid_i && (wb_rd_idx_i != '0) && !flush_i;
  assign same_reg = inc_hit && wb_hit && (dec_rd_idx_i == wb_rd_idx_i);

  // Counter next state; an increment and a writeback to the same register cancel.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush_i || (r == 0)) begin
        cnt_d[r] = '0;
      end else if (!same_reg) begin
        if (inc_hit && (dec_rd_idx_i == IDX_W'(r))) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
        if (wb_hit && (wb_rd_idx_i == IDX_W'(r)) && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  assign err_d = err_q || (wb_hit && !same_reg && (wb_cnt == '0));

  // Pending flags before and after this edge's updates.
  always_comb begin
    pending_any_o = 1'b0;
    pending_d     = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) pending_any_o = 1'b1;
      if (cnt_d[r] != '0) pending_d     = 1'b1;
    end
  end

  // Drain sequencing; a flush always returns to RUN.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!pending_d)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush_i) state_d = ST_RUN;
    drain_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign drain_done_o    = drain_done_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by
// random traffic, all compared against a per-register counter model kept here.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module tb_reg_scoreboard;

  localparam int unsigned NR   = 32;
  localparam int unsigned IW   = `REG_IDX_WIDTH;
  localparam int          CMAX = 3;
`ifdef SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dec_valid, rs1_en, rs2_en, rd_en, wb_valid, flush, drain_req;
  logic [IW-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic          issue_ready_o, drain_done_o, pending_any_o, err_underflow_o;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(NR), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid),
    .dec_rs1_en_i(rs1_en), .dec_rs1_idx_i(rs1_idx),
    .dec_rs2_en_i(rs2_en), .dec_rs2_idx_i(rs2_idx),
    .dec_rd_en_i(rd_en),   .dec_rd_idx_i(rd_idx),
    .issue_ready_o(issue_ready_o),
    .wb_valid_i(wb_valid), .wb_rd_idx_i(wb_idx),
    .flush_i(flush), .drain_req_i(drain_req),
    .drain_done_o(drain_done_o), .pending_any_o(pending_any_o),
    .err_underflow_o(err_underflow_o)
  );

  // Reference model: outstanding writes per register, drain mode (0 run, 1 drain, 2 done), error flag.
  int mcnt[NR];
  int mode;
  bit merr;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit src_hazard(input logic en, input int idx);
    if (!en || idx == 0 || mcnt[idx] == 0) return 1'b0;
    if (BYP && wb_valid && int'(wb_idx) == idx && mcnt[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    if (mode != 0 || drain_req || flush) return 1'b0;
    if (src_hazard(rs1_en, int'(rs1_idx))) return 1'b0;
    if (src_hazard(rs2_en, int'(rs2_idx))) return 1'b0;
    if (rd_en && rd_idx != 0 && mcnt[rd_idx] == CMAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_pending();
    for (int r = 0; r < NR; r++) if (mcnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(input logic v, input logic r1e, input int r1, input logic r2e, input int r2,
                        input logic rde, input int rd, input logic wbv, input int wbr,
                        input logic fl, input logic dr);
    dec_valid = v;
    rs1_en = r1e; rs1_idx = IW'(r1);
    rs2_en = r2e; rs2_idx = IW'(r2);
    rd_en  = rde; rd_idx  = IW'(rd);
    wb_valid = wbv; wb_idx = IW'(wbr);
    flush = fl; drain_req = dr;
  endtask

  // Check all outputs against the model, advance the model, then cross one clock edge.
  task automatic step(input string tag);
    bit rdy, fire, rdh, wbh;
    #1;
    rdy = model_ready();
    check({tag, "_ready"}, issue_ready_o, rdy);
    check({tag, "_pend"},  pending_any_o, model_pending());
    check({tag, "_done"},  drain_done_o, mode == 2);
    check({tag, "_err"},   err_underflow_o, merr);
    fire = dec_valid && rdy;
    if (flush) begin
      for (int r = 0; r < NR; r++) mcnt[r] = 0;
      mode = 0;
    end else begin
      rdh = fire && rd_en && rd_idx != 0;
      wbh = wb_valid && wb_idx != 0;
      if (!(rdh && wbh && rd_idx == wb_idx)) begin
        if (rdh) mcnt[rd_idx]++;
        if (wbh) begin
          if (mcnt[wb_idx] > 0) mcnt[wb_idx]--;
          else merr = 1'b1;
        end
      end
      if (mode == 0) begin
        if (drain_req) mode = 1;
      end else if (mode == 1) begin
        if (!model_pending()) mode = 2;
      end else begin
        mode = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    mode = 0;
    merr = 1'b0;
    set_in(1, 1, 3, 1, 4, 1, 3, 0, 0, 0, 0);
    #1;
    check({tag, "_ready"}, issue_ready_o, 1'b1);
    check({tag, "_pend"},  pending_any_o, 1'b0);
    check({tag, "_done"},  drain_done_o, 1'b0);
    check({tag, "_err"},   err_underflow_o, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cand[$];
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset("rst0");

    // RAW on x3: stall until the writeback (same cycle with bypass).
    set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); #1;
    check("raw_issue_x3", issue_ready_o, 1'b1);
    step("raw_a");
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("raw_stall", issue_ready_o, 1'b0);
    step("raw_b");
    set_in(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0); #1;
    check("raw_wb_cycle", issue_ready_o, BYP);
    step("raw_c");
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("raw_after_wb", issue_ready_o, 1'b1);
    step("raw_d");

    // Saturation on x5.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      step("sat_fill");
    end
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); #1;
    check("sat_block", issue_ready_o, 1'b0);
    step("sat_b");
    set_in(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
    step("sat_wb");
    set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); #1;
    check("sat_release", issue_ready_o, 1'b1);
    step("sat_c");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      step("sat_drainout");
    end

    // Same-cycle fire and writeback on x7.
    set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step("same_a");
    set_in(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    step("same_b");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("same_pending", pending_any_o, 1'b1);
    check("same_no_err", err_underflow_o, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step("same_c");

    // Writeback to x0 is ignored; writeback to idle x9 sets the sticky error.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("wb_x0");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("wb_x0_no_err", err_underflow_o, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step("uf_a");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("uf_set", err_underflow_o, 1'b1);
    step("uf_b");
    check("uf_sticky", err_underflow_o, 1'b1);

    // Drain with two outstanding writes to x4.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
      step("drn_fill");
    end
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1); #1;
    check("drn_req_block", issue_ready_o, 1'b0);
    step("drn_a");
    set_in(1, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0);
    step("drn_wb1");
    step("drn_wb2");
    set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); #1;
    check("drn_done_pulse", drain_done_o, 1'b1);
    check("drn_done_block", issue_ready_o, 1'b0);
    step("drn_b");
    check("drn_done_low", drain_done_o, 1'b0);
    check("drn_ready_back", issue_ready_o, 1'b1);
    step("drn_c");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step("drn_clean");

    // Flush mid-drain with x6 pending, then reset mid-drain.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
      step("fl_fill");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("fl_enter");
    set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    step("fl_hold");
    set_in(1, 0, 0, 0, 0, 1, 2, 1, 6, 1, 0); #1;
    check("fl_blocks_issue", issue_ready_o, 1'b0);
    step("fl_flush");
    set_in(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("fl_pend_clear", pending_any_o, 1'b0);
    check("fl_no_done", drain_done_o, 1'b0);
    check("fl_run", issue_ready_o, 1'b1);
    step("fl_after");
    set_in(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    step("rd_fill");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rd_enter");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rd_hold");
    do_reset("rst_mid_drain");

    // Random traffic on a small register window to provoke hazards and saturation.
    for (int i = 0; i < 800; i++) begin
      dec_valid = ($urandom_range(3, 0) != 0);
      rs1_en    = 1'($urandom_range(1, 0));
      rs1_idx   = IW'($urandom_range(7, 0));
      rs2_en    = 1'($urandom_range(1, 0));
      rs2_idx   = IW'($urandom_range(7, 0));
      rd_en     = ($urandom_range(3, 0) != 0);
      rd_idx    = IW'($urandom_range(7, 0));
      wb_valid  = 1'($urandom_range(1, 0));
      cand.delete();
      for (int r = 1; r < NR; r++) if (mcnt[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(9, 0) != 0)
        wb_idx = IW'(cand[$urandom_range(cand.size() - 1, 0)]);
      else
        wb_idx = IW'($urandom_range(7, 0));
      flush     = ($urandom_range(40, 0) == 0);
      drain_req = ($urandom_range(9, 0) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
